// File: rtl/opc_trace_pkg.sv
// Shared types and default sizing for the microcode PC trace controller.
package opc_trace_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultPcW   = 14;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StFrozen
  } trace_state_e;

endpackage

// File: rtl/opc_trace_ctrl_if.sv
// Capture, trigger and readback signals of the PC trace controller.
interface opc_trace_ctrl_if
  import opc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned PC_W  = DefaultPcW
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_W-1:0] pc;
  logic            state_fetch;
  logic            opcclk;
  logic            opcinh;
  logic            arm;
  logic            disarm;
  logic [PC_W-1:0] trig_pc;
  logic [AW-1:0]   post_cnt;
  logic            rd_req;
  logic [AW-1:0]   rd_idx;
  logic [PC_W-1:0] opc;
  logic            rd_ack;
  logic [PC_W-1:0] rd_data;
  logic [AW:0]     count;
  logic            frozen;

  modport master (
    output pc, state_fetch, opcclk, opcinh, arm, disarm, trig_pc, post_cnt, rd_req, rd_idx,
    input  opc, rd_ack, rd_data, count, frozen
  );

  modport slave (
    input  pc, state_fetch, opcclk, opcinh, arm, disarm, trig_pc, post_cnt, rd_req, rd_idx,
    output opc, rd_ack, rd_data, count, frozen
  );

endinterface

// File: rtl/opc_trace_ram.sv
// PC history storage: one synchronous write port, one read-first synchronous read port.
module opc_trace_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 14
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PC_W-1:0]          wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PC_W-1:0]          rdata
);

  logic [PC_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the controller's count qualifies entries.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/opc_trace_ctrl.sv
// Microcode PC trace buffer with arm/trigger/post-count freeze and aged readback.
module opc_trace_ctrl
  import opc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned PC_W  = DefaultPcW
) (
  input  logic           clk,
  input  logic           reset,
  opc_trace_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  trace_state_e    state_q;
  logic [PC_W-1:0] opc_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   remaining_q;
  logic            frozen_q;
  logic            rd_ack_q;
  logic            rd_hit_q;

  logic            save;
  logic            capture;
  logic            trig_hit;
  logic [AW-1:0]   rd_addr;
  logic [PC_W-1:0] ram_rdata;

  assign save     = (bus.state_fetch | bus.opcclk) & ~bus.opcinh;
  assign capture  = save && (state_q != StFrozen);
  assign trig_hit = save && (bus.pc == bus.trig_pc);
  // Age 0 is the entry just behind the write pointer.
  assign rd_addr  = wr_ptr_q - AW'(1) - bus.rd_idx;

  opc_trace_ram #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr_q),
    .wdata (bus.pc),
    .re    (bus.rd_req),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      opc_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      frozen_q    <= 1'b0;
    end else begin
      if (capture) begin
        opc_q    <= bus.pc;
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != Full) count_q <= count_q + CW'(1);
      end
      if (bus.disarm) begin
        state_q     <= StIdle;
        remaining_q <= '0;
        frozen_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.arm) state_q <= StArmed;
          end
          StArmed: begin
            if (trig_hit) begin
              if (bus.post_cnt == '0) begin
                state_q  <= StFrozen;
                frozen_q <= 1'b1;
              end else begin
                state_q     <= StPost;
                remaining_q <= bus.post_cnt;
              end
            end
          end
          StPost: begin
            if (save) begin
              remaining_q <= remaining_q - AW'(1);
              if (remaining_q == AW'(1)) begin
                state_q  <= StFrozen;
                frozen_q <= 1'b1;
              end
            end
          end
          StFrozen: begin
            if (bus.arm) begin
              state_q  <= StArmed;
              frozen_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Hit flag only moves with a request, so rd_data holds between acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_q <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_ack_q <= bus.rd_req;
      if (bus.rd_req) rd_hit_q <= ({1'b0, bus.rd_idx} < count_q);
    end
  end

  assign bus.opc     = opc_q;
  assign bus.count   = count_q;
  assign bus.frozen  = frozen_q;
  assign bus.rd_ack  = rd_ack_q;
  assign bus.rd_data = rd_hit_q ? ram_rdata : '0;

endmodule

// File: tb/tb_opc_trace_ctrl.sv
// Directed bench for opc_trace_ctrl with hand-computed expectations.
module tb_opc_trace_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 14;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  opc_trace_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  opc_trace_ctrl #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic save_pc(input logic [13:0] pc, input bit use_opcclk);
    bus.pc = pc;
    if (use_opcclk) bus.opcclk = 1'b1;
    else bus.state_fetch = 1'b1;
    tick();
    bus.state_fetch = 1'b0;
    bus.opcclk      = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] idx, input logic [13:0] exp);
    bus.rd_req = 1'b1;
    bus.rd_idx = idx;
    tick();
    bus.rd_req = 1'b0;
    check_eq({tag, "_ack"}, 32'(bus.rd_ack), 32'd1);
    check_eq({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    tick();
    check_eq({tag, "_ack_drop"}, 32'(bus.rd_ack), 32'd0);
    check_eq({tag, "_hold"}, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  initial begin
    bus.pc = '0; bus.state_fetch = 0; bus.opcclk = 0; bus.opcinh = 0;
    bus.arm = 0; bus.disarm = 0; bus.trig_pc = '0; bus.post_cnt = '0;
    bus.rd_req = 0; bus.rd_idx = '0;

    // Reset overrides a concurrent save, arm and read.
    reset = 1'b1;
    bus.state_fetch = 1'b1; bus.arm = 1'b1; bus.rd_req = 1'b1; bus.pc = 14'h0AA;
    tick(); tick();
    bus.state_fetch = 1'b0; bus.arm = 1'b0; bus.rd_req = 1'b0;
    reset = 1'b0;
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_opc", 32'(bus.opc), 32'd0);
    check_eq("rst_frozen", 32'(bus.frozen), 32'd0);
    check_eq("rst_ack", 32'(bus.rd_ack), 32'd0);
    check_eq("rst_rdata", 32'(bus.rd_data), 32'd0);

    // Free-run: ten saves, count saturates at DEPTH.
    for (int i = 0; i < 10; i++) save_pc(14'(14'h100 + i), (i % 2) == 1);
    check_eq("run_count", 32'(bus.count), 32'd8);
    check_eq("run_opc", 32'(bus.opc), 32'h109);
    read_chk("rd_age0", 3'd0, 14'h109);
    read_chk("rd_age7", 3'd7, 14'h102);
    read_chk("rd_age3", 3'd3, 14'h106);

    // Inhibited save.
    bus.opcinh = 1'b1;
    save_pc(14'h3FFF, 1'b0);
    bus.opcinh = 1'b0;
    check_eq("inh_opc", 32'(bus.opc), 32'h109);
    check_eq("inh_count", 32'(bus.count), 32'd8);

    // Trigger at 0x200 with three post captures.
    bus.trig_pc = 14'h200; bus.post_cnt = 3'd3;
    pulse_arm();
    for (int i = 0; i < 8; i++) begin
      save_pc(14'(14'h1FE + i), 1'b0);
      check_eq($sformatf("post_frozen_%0h", 14'h1FE + i), 32'(bus.frozen),
               (14'h1FE + i >= 14'h203) ? 32'd1 : 32'd0);
    end
    check_eq("post_opc", 32'(bus.opc), 32'h203);
    read_chk("frz_age0", 3'd0, 14'h203);
    read_chk("frz_age3", 3'd3, 14'h200);
    // Back-to-back reads.
    bus.rd_req = 1'b1; bus.rd_idx = 3'd0;
    tick();
    bus.rd_idx = 3'd1;
    check_eq("b2b_ack0", 32'(bus.rd_ack), 32'd1);
    check_eq("b2b_data0", 32'(bus.rd_data), 32'h203);
    tick();
    bus.rd_req = 1'b0;
    check_eq("b2b_ack1", 32'(bus.rd_ack), 32'd1);
    check_eq("b2b_data1", 32'(bus.rd_data), 32'h202);
    tick();

    // Disarm, then immediate freeze with post_cnt = 0.
    bus.disarm = 1'b1; tick(); bus.disarm = 1'b0;
    check_eq("disarm_frozen", 32'(bus.frozen), 32'd0);
    bus.trig_pc = 14'h055; bus.post_cnt = 3'd0;
    pulse_arm();
    save_pc(14'h054, 1'b0);
    check_eq("p0_pre_frozen", 32'(bus.frozen), 32'd0);
    save_pc(14'h055, 1'b1);
    check_eq("p0_frozen", 32'(bus.frozen), 32'd1);
    check_eq("p0_opc", 32'(bus.opc), 32'h055);

    // Arm coinciding with a save in FROZEN does not capture.
    bus.arm = 1'b1;
    save_pc(14'h077, 1'b0);
    bus.arm = 1'b0;
    check_eq("rearm_opc", 32'(bus.opc), 32'h055);
    check_eq("rearm_frozen", 32'(bus.frozen), 32'd0);
    save_pc(14'h078, 1'b0);
    check_eq("rearm_cap", 32'(bus.opc), 32'h078);
    // Disarm coinciding with a save still captures.
    bus.disarm = 1'b1;
    save_pc(14'h079, 1'b0);
    bus.disarm = 1'b0;
    check_eq("disarm_cap", 32'(bus.opc), 32'h079);

    // Fresh reset, three captures, out-of-range read.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) save_pc(14'(14'h010 + i), 1'b0);
    check_eq("few_count", 32'(bus.count), 32'd3);
    read_chk("rd_oob", 3'd5, 14'h000);
    read_chk("rd_oldest", 3'd2, 14'h010);

    // arm + disarm same cycle stays IDLE: a matching save must not freeze.
    bus.trig_pc = 14'h013; bus.post_cnt = 3'd0;
    bus.arm = 1'b1; bus.disarm = 1'b1; tick(); bus.arm = 1'b0; bus.disarm = 1'b0;
    save_pc(14'h013, 1'b0);
    check_eq("armdis_frozen", 32'(bus.frozen), 32'd0);
    check_eq("armdis_opc", 32'(bus.opc), 32'h013);

    // Reset mid-POST (remaining = 2) with a read pending.
    bus.trig_pc = 14'h020; bus.post_cnt = 3'd3;
    pulse_arm();
    save_pc(14'h020, 1'b0);
    save_pc(14'h021, 1'b0);
    bus.rd_req = 1'b1; bus.rd_idx = 3'd0; reset = 1'b1;
    tick();
    bus.rd_req = 1'b0; reset = 1'b0;
    check_eq("midpost_ack", 32'(bus.rd_ack), 32'd0);
    check_eq("midpost_count", 32'(bus.count), 32'd0);
    check_eq("midpost_frozen", 32'(bus.frozen), 32'd0);
    save_pc(14'h022, 1'b0);
    save_pc(14'h023, 1'b0);
    check_eq("midpost_idle_frozen", 32'(bus.frozen), 32'd0);
    check_eq("midpost_idle_count", 32'(bus.count), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/opc_trace_ctrl.md
OPC_TRACE_CTRL -- requirements
Module: opc_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of PC history entries (power of two, 2..64).
REQ-002 SHALL have parameter PC_W, default 14, PC width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pc  input  PC_W  current microcode PC.
REQ-006 SHALL have port state_fetch  input  1  fetch-state strobe.
REQ-007 SHALL have port opcclk  input  1  explicit OPC save strobe.
REQ-008 SHALL have port opcinh  input  1  OPC save inhibit.
REQ-009 SHALL have port arm  input  1  single-cycle pulse that arms the trigger.
REQ-010 SHALL have port disarm  input  1  single-cycle pulse that returns to free-run.
REQ-011 SHALL have port trig_pc  input  PC_W  trigger match address.
REQ-012 SHALL have port post_cnt  input  log2(DEPTH)  captures taken after the trigger before freezing.
REQ-013 SHALL have port rd_req  input  1  single-cycle read request.
REQ-014 SHALL have port rd_idx  input  log2(DEPTH)  entry age to read (0 = newest).
REQ-015 SHALL have port opc  output  PC_W  most recently captured PC.
REQ-016 SHALL have port rd_ack  output  1  read data valid, one-cycle pulse.
REQ-017 SHALL have port rd_data  output  PC_W  read result.
REQ-018 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-019 SHALL have port frozen  output  1  high while in FROZEN.

Function
REQ-020 save = (state_fetch | opcclk) & ~opcinh; a capture SHALL occur on save in every state except FROZEN.
REQ-021 Capture: buffer[wr_ptr] <= pc, opc <= pc, wr_ptr increments modulo DEPTH, count increments saturating at DEPTH; all in the same edge.
REQ-022 States: IDLE (free-run capture), ARMED (capture plus compare), POST (capture plus countdown), FROZEN (no capture).
REQ-023 IDLE or FROZEN + arm -> ARMED; buffer contents and count are retained.
REQ-024 ARMED + save with pc == trig_pc: captures that pc; -> FROZEN if post_cnt == 0, else -> POST with remaining = post_cnt (sampled on that edge).
REQ-025 POST + save: captures, decrements remaining; -> FROZEN on the capture that brings remaining to 0.
REQ-026 disarm in any state -> IDLE; disarm and arm asserted in the same cycle -> disarm wins.
REQ-027 disarm coinciding with a save SHALL still perform that capture; arm coinciding with a save in FROZEN SHALL NOT capture (capture resumes the next cycle).
REQ-028 frozen SHALL be high exactly when state is FROZEN (registered state, no combinational path from inputs).
REQ-029 rd_req in cycle N -> rd_ack high in cycle N+1 only, rd_data = entry at age rd_idx, i.e. buffer[(wr_ptr-1-rd_idx) mod DEPTH], evaluated before any capture on the edge ending cycle N.
REQ-030 rd_idx >= count -> rd_data SHALL be 0 with rd_ack still asserted.
REQ-031 Back-to-back rd_req each cycle SHALL give back-to-back rd_ack; reads are legal in every state and never stall capture.
REQ-032 rd_data SHALL hold its last value when rd_ack is low.

Reset
REQ-033 reset SHALL force state IDLE, opc 0, wr_ptr 0, count 0, remaining 0, rd_ack 0, rd_data 0, frozen 0, overriding all other inputs in that cycle.
REQ-034 Buffer storage SHALL NOT be reset; count alone defines validity.
REQ-035 reset asserted mid-POST or mid-read SHALL discard the pending freeze and suppress the pending rd_ack.

Structure
REQ-036 Package opc_trace_pkg SHALL hold the state enumeration, DEPTH default and PC_W default.
REQ-037 Storage SHALL be a sub-module opc_trace_ram: DEPTH x PC_W, one synchronous write port, one synchronous read port.

Verification
REQ-038 Reset, then 10 saves with pc = 0x100..0x109 in IDLE -> count = 8, opc = 0x109, rd_idx 0 -> 0x109, rd_idx 7 -> 0x102.
REQ-039 Save with opcinh = 1, pc = 0x3FFF -> no capture, opc and count unchanged.
REQ-040 arm, trig_pc = 0x0200, post_cnt = 3, saves pc = 0x1FE..0x205 -> FROZEN after capture of 0x203; further saves ignored; rd_idx 0 -> 0x203, rd_idx 3 -> 0x200.
REQ-041 post_cnt = 0 trigger on 0x0055 -> frozen high the cycle after the matching save, opc = 0x0055.
REQ-042 After reset with 3 captures, rd_idx 5 -> rd_ack with rd_data 0; arm+disarm same cycle -> state IDLE.
REQ-043 reset asserted in POST with remaining = 2 and rd_req pending -> next cycle IDLE, count 0, rd_ack 0.
